// File: rtl/speed_detector.sv
// Pulse-period checker for the rate-divider enable stream: measures the spacing
// between input events, maps it back to a 2-bit speed code and reports lock/timeout.
module speed_detector #(
  parameter int CLOCK_FREQUENCY = 500,
  parameter int TOLERANCE       = 8,
  parameter int LOCK_COUNT      = 2,
  localparam int TMAX           = 4 * CLOCK_FREQUENCY + TOLERANCE,
  localparam int CW             = $clog2(TMAX + 1)
) (
  input  logic          ClockIn,
  input  logic          Reset,
  input  logic          PulseIn,
  output logic [1:0]    SpeedOut,
  output logic [CW-1:0] PeriodOut,
  output logic          MeasValid,
  output logic          Unknown,
  output logic          Locked,
  output logic          Timeout
);

  localparam int MW = $clog2(LOCK_COUNT + 1);

  localparam logic [CW-1:0] TMAX_C = CW'(TMAX);
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW:0]   NOM1_W = (CW + 1)'(CLOCK_FREQUENCY);
  localparam logic [CW:0]   NOM2_W = (CW + 1)'(2 * CLOCK_FREQUENCY);
  localparam logic [CW:0]   NOM4_W = (CW + 1)'(4 * CLOCK_FREQUENCY);
  localparam logic [CW:0]   TOL_W  = (CW + 1)'(TOLERANCE);
  localparam logic [MW-1:0] LOCK_C = MW'(LOCK_COUNT);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [MW-1:0] match_q, match_d;
  logic [1:0]    speed_q, speed_d;
  logic [CW-1:0] period_q, period_d;
  logic          valid_q, valid_d;
  logic          unknown_q, unknown_d;
  logic          locked_q, locked_d;
  logic          timeout_q, timeout_d;
  logic [2:0]    class_s;

  function automatic logic [CW:0] abs_diff(input logic [CW:0] a, input logic [CW:0] b);
    abs_diff = (a >= b) ? (a - b) : (b - a);
  endfunction

  // Result is {unknown, code}; the one extra bit of width keeps differences from wrapping.
  function automatic logic [2:0] classify(input logic [CW-1:0] p);
    logic [CW:0] pw;
    pw = {1'b0, p};
    if (p == ONE_C)                         classify = 3'b000;
    else if (abs_diff(pw, NOM1_W) <= TOL_W) classify = 3'b001;
    else if (abs_diff(pw, NOM2_W) <= TOL_W) classify = 3'b010;
    else if (abs_diff(pw, NOM4_W) <= TOL_W) classify = 3'b011;
    else                                    classify = 3'b100;
  endfunction

  assign class_s = classify(count_q);

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    match_d   = match_q;
    speed_d   = speed_q;
    period_d  = period_q;
    unknown_d = unknown_q;
    valid_d   = 1'b0;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (PulseIn) begin
          count_d = ONE_C;
          state_d = ST_MEASURE;
        end else begin
          count_d = count_q;
        end
      end
      ST_MEASURE: begin
        // An event on the TMAX cycle is still a measurement, so it is tested first.
        if (PulseIn) begin
          period_d = count_q;
          valid_d  = 1'b1;
          count_d  = ONE_C;
          if (class_s[2]) begin
            unknown_d = 1'b1;
            match_d   = '0;
          end else begin
            unknown_d = 1'b0;
            speed_d   = class_s[1:0];
            if ((class_s[1:0] == speed_q) && (match_q != '0)) begin
              match_d = (match_q >= LOCK_C) ? match_q : match_q + 1'b1;
            end else begin
              match_d = MW'(1);
            end
          end
        end else if (count_q == TMAX_C) begin
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
          match_d   = '0;
          count_d   = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        count_d = '0;
        match_d = '0;
      end
    endcase
    locked_d = (match_d >= LOCK_C);
  end

  always_ff @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      match_q   <= '0;
      speed_q   <= 2'b00;
      period_q  <= '0;
      valid_q   <= 1'b0;
      unknown_q <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      match_q   <= match_d;
      speed_q   <= speed_d;
      period_q  <= period_d;
      valid_q   <= valid_d;
      unknown_q <= unknown_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign SpeedOut  = speed_q;
  assign PeriodOut = period_q;
  assign MeasValid = valid_q;
  assign Unknown   = unknown_q;
  assign Locked    = locked_q;
  assign Timeout   = timeout_q;

endmodule

// File: tb/tb_speed_detector.sv
// Bench for speed_detector: an event-time reference model compared every cycle,
// directed scenarios with literal expectations, then randomized pulse trains.
module tb_speed_detector;

  localparam int F    = 500;
  localparam int TOL  = 8;
  localparam int LC   = 2;
  localparam int TMAX = 4 * F + TOL;
  localparam int CW   = $clog2(TMAX + 1);

  logic          ClockIn = 1'b0;
  logic          Reset   = 1'b1;
  logic          PulseIn = 1'b0;
  logic [1:0]    SpeedOut;
  logic [CW-1:0] PeriodOut;
  logic          MeasValid, Unknown, Locked, Timeout;

  int checks = 0;
  int errors = 0;

  speed_detector #(.CLOCK_FREQUENCY(F), .TOLERANCE(TOL), .LOCK_COUNT(LC)) dut (
    .ClockIn(ClockIn), .Reset(Reset), .PulseIn(PulseIn),
    .SpeedOut(SpeedOut), .PeriodOut(PeriodOut), .MeasValid(MeasValid),
    .Unknown(Unknown), .Locked(Locked), .Timeout(Timeout)
  );

  always #5 ClockIn = ~ClockIn;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: event timestamps and a history of recent codes.
  int  cyc = 0, last_ev = 0;
  bit  armed = 0;
  int  hist[$];
  int  m_speed = 0, m_period = 0;
  bit  m_valid = 0, m_unknown = 0, m_locked = 0, m_timeout = 0;

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int code_of(input int p);
    if (p == 1) return 0;
    if (absi(p - F) <= TOL) return 1;
    if (absi(p - 2 * F) <= TOL) return 2;
    if (absi(p - 4 * F) <= TOL) return 3;
    return -1;
  endfunction

  always @(posedge ClockIn or posedge Reset) begin
    if (Reset) begin
      armed = 0; hist.delete();
      m_speed = 0; m_period = 0; m_valid = 0; m_unknown = 0; m_locked = 0; m_timeout = 0;
    end else begin
      int el, c;
      m_valid = 0; m_timeout = 0;
      if (!armed) begin
        if (PulseIn) begin armed = 1; last_ev = cyc; end
      end else begin
        el = cyc - last_ev;
        if (PulseIn) begin
          c = code_of(el);
          m_valid = 1; m_period = el; last_ev = cyc;
          if (c < 0) begin
            m_unknown = 1; hist.delete();
          end else begin
            m_unknown = 0; m_speed = c;
            if (hist.size() > 0 && hist[hist.size() - 1] != c) hist.delete();
            hist.push_back(c);
            if (hist.size() > LC) void'(hist.pop_front());
          end
        end else if (el == TMAX) begin
          m_timeout = 1; armed = 0; hist.delete();
        end
      end
      m_locked = (hist.size() >= LC);
      cyc++;
    end
  end

  always @(negedge ClockIn) begin
    chk("SpeedOut",  32'(SpeedOut),  32'(m_speed));
    chk("PeriodOut", 32'(PeriodOut), 32'(m_period));
    chk("MeasValid", 32'(MeasValid), 32'(m_valid));
    chk("Unknown",   32'(Unknown),   32'(m_unknown));
    chk("Locked",    32'(Locked),    32'(m_locked));
    chk("Timeout",   32'(Timeout),   32'(m_timeout));
    if (MeasValid && Timeout) chk("valid_timeout_excl", 32'd1, 32'd0);
  end

  // One event now, then p-1 quiet cycles: the next event lands exactly p cycles later.
  task automatic send(input int p);
    @(negedge ClockIn) PulseIn = 1'b1;
    for (int i = 0; i < p - 1; i++) @(negedge ClockIn) PulseIn = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_speed"},   32'(SpeedOut),  32'd0);
    chk({tag, "_period"},  32'(PeriodOut), 32'd0);
    chk({tag, "_valid"},   32'(MeasValid), 32'd0);
    chk({tag, "_unknown"}, 32'(Unknown),   32'd0);
    chk({tag, "_locked"},  32'(Locked),    32'd0);
    chk({tag, "_timeout"}, 32'(Timeout),   32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge ClockIn);
    chk_all_zero("reset");
    Reset = 1'b0;

    // Continuous high: every cycle is an event with period 1.
    repeat (10) @(negedge ClockIn) PulseIn = 1'b1;
    chk("hold_period", 32'(PeriodOut), 32'd1);
    chk("hold_speed",  32'(SpeedOut),  32'd0);
    chk("hold_valid",  32'(MeasValid), 32'd1);
    chk("hold_locked", 32'(Locked),    32'd1);

    repeat (3) send(500);
    chk("f_period", 32'(PeriodOut), 32'd500);
    chk("f_speed",  32'(SpeedOut),  32'd1);
    chk("f_locked", 32'(Locked),    32'd1);

    send(1000);
    send(1000);
    chk("2f_speed",  32'(SpeedOut), 32'd2);
    chk("2f_unlock", 32'(Locked),   32'd0);
    send(1000);
    chk("2f_relock", 32'(Locked),   32'd1);

    send(508); send(492); send(509);
    chk("tol_speed",  32'(SpeedOut), 32'd1);
    chk("tol_locked", 32'(Locked),   32'd1);
    send(520);
    chk("p509_unknown", 32'(Unknown),  32'd1);
    chk("p509_speed",   32'(SpeedOut), 32'd1);
    chk("p509_locked",  32'(Locked),   32'd0);
    send(500);
    chk("p520_unknown", 32'(Unknown),  32'd1);

    // Timeout: one event, then silence.
    @(negedge ClockIn) PulseIn = 1'b1;
    n = 0;
    do begin
      @(negedge ClockIn) PulseIn = 1'b0;
      n++;
    end while (!Timeout && n < 3000);
    chk("timeout_delay",  32'(n - 1), 32'(TMAX));
    chk("timeout_locked", 32'(Locked), 32'd0);
    @(negedge ClockIn) PulseIn = 1'b1;
    @(negedge ClockIn) PulseIn = 1'b0;
    chk("rearm_no_valid", 32'(MeasValid), 32'd0);
    repeat (20) @(negedge ClockIn);

    // Event exactly at Count == TMAX is a measurement.
    send(TMAX);
    send(2);
    chk("edge_period",  32'(PeriodOut), 32'(TMAX));
    chk("edge_speed",   32'(SpeedOut),  32'd3);
    chk("edge_timeout", 32'(Timeout),   32'd0);

    // Asynchronous reset mid-measurement.
    @(negedge ClockIn) PulseIn = 1'b1;
    repeat (300) @(negedge ClockIn) PulseIn = 1'b0;
    #2 Reset = 1'b1;
    #1 chk_all_zero("async_rst");
    @(negedge ClockIn) Reset = 1'b0;
    repeat (3) send(500);
    chk("post_rst_period", 32'(PeriodOut), 32'd500);

    // Randomized pulse trains.
    for (int s = 0; s < 20; s++) begin
      int kind, p, cnt;
      kind = int'($urandom_range(0, 6));
      cnt  = int'($urandom_range(1, 3));
      case (kind)
        0:       p = 1;
        1:       p = F + int'($urandom_range(0, 20)) - 10;
        2:       p = 2 * F + int'($urandom_range(0, 20)) - 10;
        3:       p = 4 * F + int'($urandom_range(0, 20)) - 10;
        4:       p = int'($urandom_range(2, 600));
        default: p = TMAX + 50;
      endcase
      repeat (cnt) send(p);
    end
    send(2);
    repeat (5) @(negedge ClockIn);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
